player_input_conditioner: RTL and testbench
===========================================

Name: player_input_conditioner

Overview:
Front end for the player's push-buttons. It synchronises and debounces the left/right/fire/reload buttons and owns the magazine (ammo) count and the reload sequence. It delivers to the game logic clean movement levels, a single-cycle gated fire pulse, the current ammo count and status pulses. It runs on the pixel clock and replaces raw-button handling and bullet counting in the game top level.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronised cycles required before a debounced level changes (10 ms at 25 MHz)
MAG_SIZE, 4, magazine capacity; ammo value after reset and after a completed reload
AMMO_W, 3, width of the ammo count; must satisfy 2^AMMO_W > MAG_SIZE
RELOAD_CYCLES, 12500000, duration of the reload sequence in cycles (0.5 s)

Ports:
vga_clk  in  1  pixel clock; all logic on its rising edge
reset  in  1  synchronous, active-high
freeze  in  1  game-over or pause; blocks all player actions
btn_left_raw  in  1  asynchronous raw button
btn_right_raw  in  1  asynchronous raw button
btn_fire_raw  in  1  asynchronous raw button
btn_reload_raw  in  1  asynchronous raw button
move_left  out  1  level: debounced left held, gated
move_right  out  1  level: debounced right held, gated
fire_pulse  out  1  one-cycle pulse: a shot is launched
empty_click  out  1  one-cycle pulse: fire pressed with ammo 0
ammo  out  AMMO_W  rounds remaining
reloading  out  1  high while the reload sequence runs

Behaviour:
- Reset: reset is synchronous, active-high; clock vga_clk. While reset is high, the following values apply:
  - All debounced levels and synchroniser flops are 0; debounce counters are 0.
  - The FSM is in READY; ammo = MAG_SIZE; reloading = 0.
  - move_left, move_right, fire_pulse and empty_click are 0.
  - Reset takes effect mid-reload; it aborts the reload and refills ammo.
- Per-button debounce:
  - A 2-flop synchroniser feeds the debounce logic.
  - When the synchronised value differs from the debounced level, the counter increments. When they are equal, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES, the level toggles and the counter clears.
  - A one-cycle rise pulse is asserted in the same cycle the level goes 0→1.
  - Latency: if raw changes before edge t and stays stable, the debounced level changes at edge t+2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Movement:
  - move_left = deb_left & ~deb_right & ~freeze. move_right is symmetric.
  - Both held gives neither; this is registered, with one cycle after the debounced level.
- Ammo FSM, states READY and RELOADING, all outputs registered.
- READY:
  - fire_rise & ammo>0 & ~freeze: fire_pulse=1 next cycle; ammo decrements.
  - fire_rise & ammo==0 & ~freeze: empty_click=1 next cycle; ammo unchanged.
  - reload_rise & ammo<MAG_SIZE & ~freeze: go to RELOADING; reload counter = RELOAD_CYCLES; reloading=1.
  - reload_rise with ammo==MAG_SIZE is ignored.
  - fire_rise and reload_rise in the same cycle: the fire rule is served and the reload is dropped (a single press never does both).
- RELOADING:
  - The counter decrements each non-frozen cycle.
  - At counter==1: ammo = MAG_SIZE, reloading = 0, go to READY on the same edge.
  - Fire presses are dropped: no fire_pulse and no empty_click.
  - A reload press is ignored.
- freeze:
  - The FSM and reload counter hold; rise pulses are discarded (not queued).
  - Debouncers keep running; ammo holds.
  - On freeze deassertion, a button still held does not fire; a new rise is required.
- Arithmetic: ammo never underflows below 0 and never exceeds MAG_SIZE. Counters are sized with clog2 of their limit.

Decomposition:
- Package game_input_pkg holds:
  - the FSM state enum {READY, RELOADING};
  - the default MAG_SIZE, DEBOUNCE_CYCLES and RELOAD_CYCLES constants;
  - the ammo width helper.
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports vga_clk, reset, raw, level, rise) is instantiated four times. The top contains the movement gating and the ammo FSM.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, RELOAD_CYCLES=10, MAG_SIZE=4.)
- Reset, then btn_fire_raw high for 20 cycles → exactly one fire_pulse at edge 7 after the raw change; ammo 4→3. A 3-cycle fire glitch → no pulse.
- Five separate clean fire presses → four fire_pulse, ammo 3,2,1,0; fifth press → empty_click=1 for one cycle, ammo stays 0.
- At ammo=1, press reload:
  - reloading=1 for 10 cycles; a fire press during this window → no pulse;
  - then ammo=4 and reloading=0.
  - Reload press at ammo=4 → no state change.
- Fire and reload debounced rises in the same cycle at ammo=2 → fire_pulse, ammo=1, reloading stays 0. Reset asserted mid-reload → ammo=4, reloading=0 next edge.
- freeze=1 while left held → move_left=0; fire press → no pulse, ammo unchanged. Release freeze with fire still held → no pulse until release and re-press. Left and right both held → both outputs 0.

Source files
------------

// File: rtl/player_input_conditioner_pkg.sv
// Shared definitions for the player input conditioner.
// Contents: ammo FSM state enum, default timing/capacity constants and the
// helper that sizes the ammo count for a given magazine capacity.
package game_input_pkg;

    typedef enum logic {
        READY     = 1'b0,
        RELOADING = 1'b1
    } ammo_state_t;

    localparam int DEF_MAG_SIZE        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;    // 10 ms at 25 MHz
    localparam int DEF_RELOAD_CYCLES   = 12500000;  // 0.5 s at 25 MHz

    // Smallest width able to hold 0..mag_size.
    function automatic int ammo_width(input int mag_size);
        return $clog2(mag_size + 1);
    endfunction

endpackage

// File: rtl/player_input_conditioner_if.sv
// Bundle between the raw button pins / game logic and the conditioner.
// master: game top side (drives freeze and raw buttons, consumes results)
// slave : player_input_conditioner
//   freeze, btn_*_raw            -> conditioner
//   move_left/right, fire_pulse,
//   empty_click, ammo, reloading <- conditioner
interface player_input_conditioner_if #(
    parameter int AMMO_W = 3
);
    logic              freeze;
    logic              btn_left_raw;
    logic              btn_right_raw;
    logic              btn_fire_raw;
    logic              btn_reload_raw;
    logic              move_left;
    logic              move_right;
    logic              fire_pulse;
    logic              empty_click;
    logic [AMMO_W-1:0] ammo;
    logic              reloading;

    modport master (
        output freeze, btn_left_raw, btn_right_raw, btn_fire_raw, btn_reload_raw,
        input  move_left, move_right, fire_pulse, empty_click, ammo, reloading
    );

    modport slave (
        input  freeze, btn_left_raw, btn_right_raw, btn_fire_raw, btn_reload_raw,
        output move_left, move_right, fire_pulse, empty_click, ammo, reloading
    );
endinterface

// File: rtl/player_input_conditioner_button_debouncer.sv
// Single push-button front end: 2-flop synchroniser followed by a
// stable-count debouncer.
// Ports:
//   vga_clk  pixel clock
//   reset    synchronous, active-high
//   raw      asynchronous button input
//   level    debounced button level
//   rise     one-cycle pulse, high in the cycle level goes 0->1
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic vga_clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            level  <= 1'b0;
            rise   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            if (sync_2 != level) begin
                // Toggle only after DEBOUNCE_CYCLES+1 consecutive
                // disagreeing samples; any agreement restarts the count.
                if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                    level <= ~level;
                    rise  <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/player_input_conditioner.sv
// Player push-button front end: debounces left/right/fire/reload, gates
// movement, and owns the magazine count and reload sequence.
// Ports:
//   vga_clk  pixel clock
//   reset    synchronous, active-high; aborts a reload and refills ammo
//   pin      player_input_conditioner_if.slave (freeze, raw buttons in;
//            move_left/right, fire_pulse, empty_click, ammo, reloading out)
//
// Ammo FSM
//   state     | meaning
//   READY     | fire/reload presses accepted
//   RELOADING | reload timer running, all presses dropped
module player_input_conditioner
    import game_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int MAG_SIZE        = DEF_MAG_SIZE,
    parameter int AMMO_W          = ammo_width(MAG_SIZE),
    parameter int RELOAD_CYCLES   = DEF_RELOAD_CYCLES
) (
    input logic                        vga_clk,
    input logic                        reset,
    player_input_conditioner_if.slave  pin
);
    localparam int RCW = $clog2(RELOAD_CYCLES + 1);

    logic deb_left, deb_right, deb_fire, deb_reload;
    logic fire_rise, reload_rise;
    logic left_rise_unused, right_rise_unused;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .vga_clk (vga_clk), .reset (reset), .raw (pin.btn_left_raw),
        .level   (deb_left), .rise (left_rise_unused)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .vga_clk (vga_clk), .reset (reset), .raw (pin.btn_right_raw),
        .level   (deb_right), .rise (right_rise_unused)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_fire (
        .vga_clk (vga_clk), .reset (reset), .raw (pin.btn_fire_raw),
        .level   (deb_fire), .rise (fire_rise)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reload (
        .vga_clk (vga_clk), .reset (reset), .raw (pin.btn_reload_raw),
        .level   (deb_reload), .rise (reload_rise)
    );

    ammo_state_t        state_q, state_n;
    logic [AMMO_W-1:0]  ammo_q, ammo_n;
    logic [RCW-1:0]     rcnt_q, rcnt_n;
    logic               fire_q, fire_n;
    logic               empty_q, empty_n;
    logic               move_left_q, move_right_q;
    logic               fire_held_unused;

    // The fire level itself is only consumed through its rise pulse.
    assign fire_held_unused = deb_fire ^ deb_reload;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q      <= READY;
            ammo_q       <= AMMO_W'(MAG_SIZE);
            rcnt_q       <= '0;
            fire_q       <= 1'b0;
            empty_q      <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            ammo_q       <= ammo_n;
            rcnt_q       <= rcnt_n;
            fire_q       <= fire_n;
            empty_q      <= empty_n;
            // Both directions held cancels out.
            move_left_q  <= deb_left  & ~deb_right & ~pin.freeze;
            move_right_q <= deb_right & ~deb_left  & ~pin.freeze;
        end
    end

    // Freeze holds everything; rise pulses arriving meanwhile are lost.
    always_comb begin
        state_n = state_q;
        ammo_n  = ammo_q;
        rcnt_n  = rcnt_q;
        fire_n  = 1'b0;
        empty_n = 1'b0;
        if (!pin.freeze) begin
            case (state_q)
                READY: begin
                    // Fire wins over a simultaneous reload press.
                    if (fire_rise) begin
                        if (ammo_q != '0) begin
                            fire_n = 1'b1;
                            ammo_n = ammo_q - AMMO_W'(1);
                        end else begin
                            empty_n = 1'b1;
                        end
                    end else if (reload_rise && (ammo_q < AMMO_W'(MAG_SIZE))) begin
                        state_n = RELOADING;
                        rcnt_n  = RCW'(RELOAD_CYCLES);
                    end
                end
                RELOADING: begin
                    if (rcnt_q <= RCW'(1)) begin
                        state_n = READY;
                        ammo_n  = AMMO_W'(MAG_SIZE);
                        rcnt_n  = '0;
                    end else begin
                        rcnt_n = rcnt_q - RCW'(1);
                    end
                end
                default: state_n = READY;
            endcase
        end
    end

    assign pin.move_left   = move_left_q;
    assign pin.move_right  = move_right_q;
    assign pin.fire_pulse  = fire_q;
    assign pin.empty_click = empty_q;
    assign pin.ammo        = ammo_q;
    assign pin.reloading   = (state_q == RELOADING);

endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner with short debounce/reload timings.
module tb_player_input_conditioner;
    localparam int D   = 4;
    localparam int RL  = 10;
    localparam int MAG = 4;

    logic vga_clk;
    logic reset;

    player_input_conditioner_if #(.AMMO_W(3)) bus ();

    player_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .MAG_SIZE        (MAG),
        .AMMO_W          (3),
        .RELOAD_CYCLES   (RL)
    ) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .pin     (bus)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int errors = 0;
    int checks = 0;
    int n_fire = 0, n_empty = 0, n_rel = 0;

    // Reference model: a button level flips once the last D+1 synchronised
    // samples (raw seen two edges earlier) all disagree with it.
    int hist [4][D+3];
    int lvl  [4];
    int rise [4];
    int m_ammo, m_rl;
    int m_move_l, m_move_r, m_fire, m_empty;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int raw [4];
        int ro  [4];
        int lo  [4];
        int frz;
        int flip;
        raw[0] = bus.btn_left_raw;
        raw[1] = bus.btn_right_raw;
        raw[2] = bus.btn_fire_raw;
        raw[3] = bus.btn_reload_raw;
        frz    = bus.freeze;
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < D+3; k++) hist[b][k] = 0;
                lvl[b]  = 0;
                rise[b] = 0;
            end
            m_ammo = MAG; m_rl = 0;
            m_move_l = 0; m_move_r = 0; m_fire = 0; m_empty = 0;
            return;
        end
        for (int b = 0; b < 4; b++) begin
            lo[b] = lvl[b];
            ro[b] = rise[b];
        end
        m_move_l = (lo[0] == 1 && lo[1] == 0 && frz == 0) ? 1 : 0;
        m_move_r = (lo[1] == 1 && lo[0] == 0 && frz == 0) ? 1 : 0;
        m_fire = 0;
        m_empty = 0;
        if (frz == 0) begin
            if (m_rl > 0) begin
                m_rl--;
                if (m_rl == 0) m_ammo = MAG;
            end else if (ro[2] == 1) begin
                if (m_ammo > 0) begin m_fire = 1; m_ammo--; end
                else m_empty = 1;
            end else if (ro[3] == 1 && m_ammo < MAG) begin
                m_rl = RL;
            end
        end
        for (int b = 0; b < 4; b++) begin
            for (int k = D+2; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = raw[b];
            flip = 1;
            for (int k = 2; k <= D+2; k++) if (hist[b][k] == lvl[b]) flip = 0;
            rise[b] = 0;
            if (flip == 1) begin
                lvl[b]  = 1 - lvl[b];
                rise[b] = lvl[b];
            end
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        model_edge();
        #1;
        check("move_left",   bus.move_left,   m_move_l);
        check("move_right",  bus.move_right,  m_move_r);
        check("fire_pulse",  bus.fire_pulse,  m_fire);
        check("empty_click", bus.empty_click, m_empty);
        check("ammo",        bus.ammo,        m_ammo);
        check("reloading",   bus.reloading,   (m_rl > 0) ? 1 : 0);
        if (bus.fire_pulse)  n_fire++;
        if (bus.empty_click) n_empty++;
        if (bus.reloading)   n_rel++;
    endtask

    task automatic set_buttons(input logic [3:0] m);
        bus.btn_left_raw   = m[0];
        bus.btn_right_raw  = m[1];
        bus.btn_fire_raw   = m[2];
        bus.btn_reload_raw = m[3];
    endtask

    task automatic do_reset();
        set_buttons(4'b0000);
        bus.freeze = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_ammo",      bus.ammo,      MAG);
        check("rst_reloading", bus.reloading, 0);
        check("rst_fire",      bus.fire_pulse, 0);
        reset = 1'b0;
    endtask

    // Hold buttons for 'hold' ticks, release for 'gap'; report pulse counts.
    task automatic run_press(input logic [3:0] m, input int hold, input int gap,
                             input logic frz, output int nf, output int ne, output int nr);
        int f0, e0, r0;
        f0 = n_fire; e0 = n_empty; r0 = n_rel;
        bus.freeze = frz;
        set_buttons(m);
        repeat (hold) tick();
        set_buttons(4'b0000);
        repeat (gap) tick();
        bus.freeze = 1'b0;
        nf = n_fire - f0; ne = n_empty - e0; nr = n_rel - r0;
    endtask

    typedef struct {
        string      name;
        logic [3:0] mask;   // [0] left [1] right [2] fire [3] reload
        int         hold;
        int         gap;
        logic       frz;
        int         exp_fire;
        int         exp_empty;
        int         exp_ammo;
        int         exp_rel;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int nf, ne, nr, nf2, ne2, nr2, k;
        reset = 1'b1;
        bus.freeze = 1'b0;
        set_buttons(4'b0000);

        tbl[0]  = '{"fire_long",    4'b0100, 20, 10, 1'b0, 1, 0, 3, 0};
        tbl[1]  = '{"fire_glitch",  4'b0100,  3, 10, 1'b0, 0, 0, 3, 0};
        tbl[2]  = '{"fire_2",       4'b0100, 10, 10, 1'b0, 1, 0, 2, 0};
        tbl[3]  = '{"fire_3",       4'b0100, 10, 10, 1'b0, 1, 0, 1, 0};
        tbl[4]  = '{"reload_a1",    4'b1000, 10, 25, 1'b0, 0, 0, 4, 0};
        tbl[5]  = '{"reload_full",  4'b1000, 10, 25, 1'b0, 0, 0, 4, 0};
        tbl[6]  = '{"fire_frozen",  4'b0100, 10, 10, 1'b1, 0, 0, 4, 0};
        tbl[7]  = '{"fire_a3",      4'b0100, 10, 10, 1'b0, 1, 0, 3, 0};
        tbl[8]  = '{"fire_a2",      4'b0100, 10, 10, 1'b0, 1, 0, 2, 0};
        tbl[9]  = '{"fire_a1",      4'b0100, 10, 10, 1'b0, 1, 0, 1, 0};
        tbl[10] = '{"fire_a0",      4'b0100, 10, 10, 1'b0, 1, 0, 0, 0};
        tbl[11] = '{"fire_empty",   4'b0100, 10, 10, 1'b0, 0, 1, 0, 0};
        tbl[12] = '{"reload_a0",    4'b1000, 10, 25, 1'b0, 0, 0, 4, 0};

        // Exact fire latency from the raw edge.
        do_reset();
        repeat (3) tick();
        bus.btn_fire_raw = 1'b1;
        k = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.fire_pulse && k < 0) k = i;
        end
        check("fire_latency", k, 7);
        check("latency_ammo", bus.ammo, 3);
        bus.btn_fire_raw = 1'b0;
        repeat (10) tick();

        // Table of single presses from a fresh reset.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            run_press(tbl[i].mask, tbl[i].hold, tbl[i].gap, tbl[i].frz, nf, ne, nr);
            check({tbl[i].name, "_fires"},  nf, tbl[i].exp_fire);
            check({tbl[i].name, "_empty"},  ne, tbl[i].exp_empty);
            check({tbl[i].name, "_ammo"},   bus.ammo, tbl[i].exp_ammo);
            check({tbl[i].name, "_rel"},    bus.reloading, tbl[i].exp_rel);
        end

        // Fire pressed during a reload is dropped; reload lasts RL cycles.
        do_reset();
        repeat (3) run_press(4'b0100, 10, 10, 1'b0, nf, ne, nr);
        check("pre_reload_ammo", bus.ammo, 1);
        run_press(4'b1000, 8, 0, 1'b0, nf, ne, nr);
        run_press(4'b0100, 8, 20, 1'b0, nf2, ne2, nr2);
        check("reload_fire_drop",  nf + nf2, 0);
        check("reload_empty_drop", ne + ne2, 0);
        check("reload_len",        nr + nr2, RL);
        check("reload_done_ammo",  bus.ammo, MAG);

        // Simultaneous fire and reload: fire is served, reload dropped.
        do_reset();
        repeat (2) run_press(4'b0100, 10, 10, 1'b0, nf, ne, nr);
        run_press(4'b1100, 10, 25, 1'b0, nf, ne, nr);
        check("both_fire", nf, 1);
        check("both_ammo", bus.ammo, 1);
        check("both_rel",  nr, 0);

        // Reset mid-reload refills and aborts.
        run_press(4'b1000, 10, 0, 1'b0, nf, ne, nr);
        check("midrel_running", bus.reloading, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrel_ammo", bus.ammo, MAG);
        check("midrel_rel",  bus.reloading, 0);
        repeat (5) tick();

        // Freeze gating of movement and fire; held fire needs a re-press.
        do_reset();
        bus.btn_left_raw = 1'b1;
        repeat (10) tick();
        check("left_held", bus.move_left, 1);
        bus.freeze = 1'b1;
        tick();
        check("left_frozen", bus.move_left, 0);
        bus.btn_fire_raw = 1'b1;
        repeat (10) tick();
        bus.freeze = 1'b0;
        nf = n_fire;
        repeat (10) tick();
        check("held_after_freeze", n_fire - nf, 0);
        check("freeze_ammo", bus.ammo, MAG);
        set_buttons(4'b0000);
        repeat (10) tick();
        run_press(4'b0100, 10, 10, 1'b0, nf, ne, nr);
        check("repress_fire", nf, 1);
        check("repress_ammo", bus.ammo, 3);

        // Both directions cancel.
        set_buttons(4'b0011);
        repeat (10) tick();
        check("both_dir_left",  bus.move_left, 0);
        check("both_dir_right", bus.move_right, 0);
        set_buttons(4'b0000);
        repeat (10) tick();

        // Random stimulus against the reference model.
        for (int s = 0; s < 250; s++) begin
            reset = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            bus.freeze = ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0;
            set_buttons(4'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 12)) tick();
        end
        reset = 1'b0;
        bus.freeze = 1'b0;
        set_buttons(4'b0000);
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
